// File: rtl/playlist_sequencer.sv
// -----------------------------------------------------------------------------
// playlist_sequencer
//
// Sequencing controller for the songbook player. Picks the song index driven
// to the songbook, holds that song's active-low restart for LOAD_CYCLES when a
// song is (re)started, and advances through the playlist on the rising edge of
// the songbook's `over` level. Modes: single, sequential, loop-all, repeat-one.
// User controls: start, stop, next, prev, pause.
//
// Parameters
//   NUM_SONGS   : playable songs, indices 0..NUM_SONGS-1 (NUM_SONGS <= 256)
//   LOAD_CYCLES : cycles song_rst_n is held low on a (re)start, >= 1
//   GAP_CYCLES  : silent cycles between consecutive songs, 0 = no gap
//
// Ports
//   clk         in  : system clock
//   rst_n       in  : synchronous active-low reset
//   start       in  : pulse, begin playback at start_index (from IDLE)
//   stop        in  : pulse, abort playback, index holds, no done pulse
//   next        in  : pulse, skip forward (wraps to 0 in every mode)
//   prev        in  : pulse, skip back (wraps only in loop-all)
//   pause_in    in  : level, freeze counters and transitions while high
//   mode        in  : 0 single, 1 sequential, 2 loop-all, 3 repeat-one
//   start_index in  : first song on start (out of range -> 0)
//   song_over   in  : level from songbook; rising edge = end of song
//   index       out : song select to the songbook
//   song_rst_n  out : active-low restart for the selected song
//   pause_out   out : pause to the songbook (always 0 in IDLE)
//   playing     out : high in LOAD, PLAY and GAP
//   done        out : one-cycle pulse when the playlist finishes naturally
//   dbg_state   out : current FSM state (0 IDLE, 1 LOAD, 2 PLAY, 3 GAP)
//
// Handshake note: every control input is sampled on the rising clock edge;
// start/stop/next/prev are single-cycle pulses with no ready/acknowledge, and
// all outputs are registered, so a control sampled at edge N is visible on
// the outputs right after that edge.
// -----------------------------------------------------------------------------
module playlist_sequencer #(
  parameter int NUM_SONGS   = 8,
  parameter int LOAD_CYCLES = 2,
  parameter int GAP_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       next,
  input  logic       prev,
  input  logic       pause_in,
  input  logic [1:0] mode,
  input  logic [7:0] start_index,
  input  logic       song_over,
  output logic [7:0] index,
  output logic       song_rst_n,
  output logic       pause_out,
  output logic       playing,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SEQ    = 2'd1;
  localparam logic [1:0] MODE_LOOP   = 2'd2;
  localparam logic [1:0] MODE_REPEAT = 2'd3;

  localparam logic [7:0]  LAST_IDX    = 8'(NUM_SONGS - 1);
  // 9 bits so that NUM_SONGS = 256 still compares correctly.
  localparam logic [8:0]  NUM_SONGS_W = 9'(NUM_SONGS);
  localparam logic [31:0] LOAD_LAST   = 32'(LOAD_CYCLES - 1);
  localparam bit          GAP_EN      = (GAP_CYCLES != 0);
  localparam logic [31:0] GAP_LAST    = GAP_EN ? 32'(GAP_CYCLES - 1) : 32'd0;

  state_t      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [31:0] cnt_q, cnt_d;
  logic        over_q, over_d;
  logic        pend_q, pend_d;
  logic        song_rst_n_q, song_rst_n_d;
  logic        pause_out_q, pause_out_d;
  logic        playing_q, playing_d;
  logic        done_q, done_d;

  logic       over_rise;
  logic       next_only;
  logic       prev_only;
  logic [7:0] idx_inc;
  logic [7:0] idx_dec;
  logic [7:0] start_sel;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      index_q      <= 8'd0;
      cnt_q        <= 32'd0;
      over_q       <= 1'b0;
      pend_q       <= 1'b0;
      song_rst_n_q <= 1'b0;
      pause_out_q  <= 1'b0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      cnt_q        <= cnt_d;
      over_q       <= over_d;
      pend_q       <= pend_d;
      song_rst_n_q <= song_rst_n_d;
      pause_out_q  <= pause_out_d;
      playing_q    <= playing_d;
      done_q       <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Index arithmetic helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_inc   = (index_q == LAST_IDX) ? 8'd0 : index_q + 8'd1;
    if (index_q == 8'd0) begin
      // Only loop-all wraps backwards; other modes clamp at the first song.
      idx_dec = (mode == MODE_LOOP) ? LAST_IDX : 8'd0;
    end else begin
      idx_dec = index_q - 8'd1;
    end
    start_sel = ({1'b0, start_index} >= NUM_SONGS_W) ? 8'd0 : start_index;
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    // The edge register tracks song_over in every state, so a level that is
    // already high when PLAY is entered never looks like a fresh edge.
    over_d    = song_over;
    over_rise = song_over & ~over_q;
    // Simultaneous next and prev cancel each other.
    next_only = next & ~prev;
    prev_only = prev & ~next;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = 32'd0;
      pend_d  = 1'b0;
    end else if (pause_in) begin
      // Frozen: counters and state hold. An end-of-song edge seen while paused
      // is remembered and acted on once pause releases.
      if (state_q == ST_PLAY && over_rise) begin
        pend_d = 1'b1;
      end
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        index_d = start_sel;
        state_d = ST_LOAD;
        cnt_d   = 32'd0;
        pend_d  = 1'b0;
      end
    end else if (next_only || prev_only) begin
      index_d = next_only ? idx_inc : idx_dec;
      state_d = ST_LOAD;
      cnt_d   = 32'd0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (cnt_q == LOAD_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = 32'd0;
            pend_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end

        ST_PLAY: begin
          if (over_rise || pend_q) begin
            pend_d = 1'b0;
            cnt_d  = 32'd0;
            // Destination after a song that continues the playlist; with no
            // gap configured the GAP state is skipped entirely.
            state_d = GAP_EN ? ST_GAP : ST_LOAD;
            unique case (mode)
              MODE_SINGLE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
              MODE_SEQ: begin
                if (index_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end else begin
                  index_d = index_q + 8'd1;
                end
              end
              MODE_LOOP: begin
                index_d = idx_inc;
              end
              MODE_REPEAT: begin
                index_d = index_q;
              end
              default: begin
                state_d = state_q;
              end
            endcase
          end
        end

        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_LOAD;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    song_rst_n_d = (state_d == ST_PLAY);
    playing_d    = (state_d != ST_IDLE);
    pause_out_d  = pause_in && (state_d != ST_IDLE);
  end

  assign index      = index_q;
  assign song_rst_n = song_rst_n_q;
  assign pause_out  = pause_out_q;
  assign playing    = playing_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_playlist_sequencer.sv
// -----------------------------------------------------------------------------
// tb_playlist_sequencer
//
// Directed bench for playlist_sequencer with NUM_SONGS=4, LOAD_CYCLES=2,
// GAP_CYCLES=3. Inputs change 1 ns after a rising edge and outputs are
// checked at that same point, i.e. after the edge that consumed the previous
// inputs. Expected values are worked out by hand from the intended behaviour.
// -----------------------------------------------------------------------------
module tb_playlist_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, stop, next, prev, pause_in, song_over;
  logic [1:0] mode;
  logic [7:0] start_index;
  logic [7:0] index;
  logic       song_rst_n, pause_out, playing, done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  playlist_sequencer #(
    .NUM_SONGS  (4),
    .LOAD_CYCLES(2),
    .GAP_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .next       (next),
    .prev       (prev),
    .pause_in   (pause_in),
    .mode       (mode),
    .start_index(start_index),
    .song_over  (song_over),
    .index      (index),
    .song_rst_n (song_rst_n),
    .pause_out  (pause_out),
    .playing    (playing),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Checker: one immediate assertion per output
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [1:0] e_state,
                     input logic [7:0] e_index, input logic e_rst,
                     input logic e_playing, input logic e_pause,
                     input logic e_done);
    n_checks++;
    assert (dbg_state === e_state) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, dbg_state, e_state);
    end
    n_checks++;
    assert (index === e_index) else begin
      n_fail++;
      $error("FAIL %s index: observed %0d expected %0d", tag, index, e_index);
    end
    n_checks++;
    assert (song_rst_n === e_rst) else begin
      n_fail++;
      $error("FAIL %s song_rst_n: observed %0b expected %0b", tag, song_rst_n, e_rst);
    end
    n_checks++;
    assert (playing === e_playing) else begin
      n_fail++;
      $error("FAIL %s playing: observed %0b expected %0b", tag, playing, e_playing);
    end
    n_checks++;
    assert (pause_out === e_pause) else begin
      n_fail++;
      $error("FAIL %s pause_out: observed %0b expected %0b", tag, pause_out, e_pause);
    end
    n_checks++;
    assert (done === e_done) else begin
      n_fail++;
      $error("FAIL %s done: observed %0b expected %0b", tag, done, e_done);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; next = 1'b0; prev = 1'b0;
    pause_in = 1'b0; song_over = 1'b0; mode = 2'd0; start_index = 8'd0;
    ticks(2);
    chk("reset", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Sequential from index 2: gap of 3, load of 2, done on last song.
    mode = 2'd1; start_index = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("seq_load_c1", S_LOAD, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("seq_load_c2", S_LOAD, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("seq_play2", S_PLAY, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("seq_play2_hold", S_PLAY, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    song_over = 1'b1;
    tick();
    chk("seq_gap_c1", S_GAP, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("seq_gap_c2", S_GAP, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("seq_gap_c3", S_GAP, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("seq_load3", S_LOAD, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("seq_play3_level_high", S_PLAY, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("seq_play3_no_edge", S_PLAY, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    song_over = 1'b0;
    tick();
    song_over = 1'b1;
    tick();
    chk("seq_done", S_IDLE, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("seq_done_clear", S_IDLE, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Loop-all: wrap 3 -> 0 through the gap, then prev wraps 0 -> 3.
    mode = 2'd2; start_index = 8'd3; song_over = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("loop_load3", S_LOAD, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("loop_play3", S_PLAY, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    song_over = 1'b1;
    tick(); song_over = 1'b0;
    chk("loop_wrap_gap", S_GAP, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    chk("loop_load0", S_LOAD, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("loop_play0", S_PLAY, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    prev = 1'b1;
    tick(); prev = 1'b0;
    chk("loop_prev_wrap", S_LOAD, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);

    // Single: next wraps 3 -> 0, prev at 0 clamps and restarts the song.
    mode = 2'd0; next = 1'b1;
    tick(); next = 1'b0;
    chk("single_next_wrap", S_LOAD, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("single_play0", S_PLAY, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    prev = 1'b1;
    tick(); prev = 1'b0;
    chk("single_prev_clamp", S_LOAD, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("single_reload_c2", S_LOAD, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("single_replay", S_PLAY, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    song_over = 1'b1;
    tick(); song_over = 1'b0;
    chk("single_done", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Repeat-one with a 10-cycle pause in the middle of the gap.
    mode = 2'd3; start_index = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    ticks(2);
    chk("rep_play1", S_PLAY, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    song_over = 1'b1;
    tick(); song_over = 1'b0;
    chk("rep_gap_c1", S_GAP, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    pause_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rep_gap_paused", S_GAP, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    pause_in = 1'b0;
    tick();
    chk("rep_gap_c2", S_GAP, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rep_gap_c3", S_GAP, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rep_load1", S_LOAD, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // next+prev together are ignored; stop beats next.
    next = 1'b1; prev = 1'b1;
    tick(); next = 1'b0; prev = 1'b0;
    chk("both_ignored", S_LOAD, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("both_then_play", S_PLAY, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1; next = 1'b1;
    tick(); stop = 1'b0; next = 1'b0;
    chk("stop_beats_next", S_IDLE, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Over edge during pause is held and acted on at release.
    mode = 2'd1; start_index = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    ticks(2);
    chk("held_play0", S_PLAY, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pause_in = 1'b1; song_over = 1'b1;
    tick();
    chk("held_paused_edge", S_PLAY, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    song_over = 1'b0;
    tick();
    chk("held_paused_wait", S_PLAY, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    pause_in = 1'b0;
    tick();
    chk("held_edge_release", S_GAP, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick(); stop = 1'b0;
    chk("held_stop", S_IDLE, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Out-of-range start index, then reset in PLAY.
    start_index = 8'd9; start = 1'b1;
    tick(); start = 1'b0;
    chk("bad_start_index", S_LOAD, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    next = 1'b1;
    tick(); next = 1'b0;
    chk("bad_next", S_LOAD, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("bad_play1", S_PLAY, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("reset_mid_song", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // pause_out stays low in IDLE.
    pause_in = 1'b1;
    tick();
    chk("idle_pause", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pause_in = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
